// File: rtl/rca_ft_pkg.sv
// Shared types and the reference full-adder used by the fault-tolerant adder.
package rca_ft_pkg;

    // Fault-injection selector applied to one physical slice.
    typedef enum logic [1:0] {
        INJ_NONE = 2'b00,
        INJ_SUM0 = 2'b01,
        INJ_SUM1 = 2'b10,
        INJ_CINV = 2'b11
    } inj_mode_e;

    // BIST sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TEST,
        ST_REMAP,
        ST_DONE
    } bist_state_e;

    // Ideal full adder, returns {carry, sum}.
    function automatic logic [1:0] fa_golden(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/ft_fa_slice.sv
// One physical full-adder slice with an optional overlaid fault.
module ft_fa_slice
    import rca_ft_pkg::*;
(
    input  logic      a,
    input  logic      b,
    input  logic      ci,
    input  inj_mode_e mode,
    output logic      s,
    output logic      co
);

    logic [1:0] golden;

    // Compute the ideal result, then overlay the selected fault.
    always_comb begin
        // NOTE: both outputs get a value before the case, so no path leaves them unassigned (no latch).
        golden = fa_golden(a, b, ci);
        s      = golden[0];
        co     = golden[1];
        case (mode)
            INJ_SUM0: s  = 1'b0;
            INJ_SUM1: s  = 1'b1;
            INJ_CINV: co = ~golden[1];
            default:  ;
        endcase
    end

endmodule

// File: rtl/rca_ft_reconfig.sv
// Fault-tolerant ripple-carry adder with spare slices, built-in self test
// and automatic remapping of logical bits onto healthy physical slices.
module rca_ft_reconfig
    import rca_ft_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SPARES = 1,
    parameter int IDX_W  = $clog2(WIDTH + SPARES)
) (
    input  logic                     clk,
    input  logic                     init,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     cin,
    input  logic                     in_valid,
    output logic [WIDTH-1:0]         s,
    output logic                     cout,
    output logic                     out_valid,
    input  logic                     start_bist,
    output logic                     bist_busy,
    output logic                     bist_done,
    output logic [WIDTH+SPARES-1:0]  sf,
    output logic [WIDTH+SPARES-1:0]  cf,
    output logic                     unrepairable,
    input  logic                     inj_en,
    input  logic [IDX_W-1:0]         inj_slice,
    input  logic [1:0]               inj_mode
);

    localparam int P = WIDTH + SPARES;

    bist_state_e      state, state_nxt;
    logic [IDX_W-1:0] k;
    logic [2:0]       v;
    logic             test_mode;
    logic [1:0]       golden;

    logic [IDX_W-1:0] map   [WIDTH];
    logic [IDX_W-1:0] remap [WIDTH];
    logic [P-1:0]     faulty;
    logic             repairable;
    int               free_cnt;
    int               fault_cnt;

    logic [P-1:0]     pa, pb, used, slice_s, slice_c;
    logic [WIDTH-1:0] sum_nxt;
    logic             cout_nxt;

    // BIST state register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (init) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state and status decode for the BIST sequencer.
    always_comb begin
        state_nxt = state;
        bist_busy = 1'b0;
        bist_done = 1'b0;
        test_mode = 1'b0;
        case (state)
            ST_IDLE:  if (start_bist) state_nxt = ST_TEST;
            ST_TEST: begin
                bist_busy = 1'b1;
                test_mode = 1'b1;
                if (k == IDX_W'(P - 1) && v == 3'd7) state_nxt = ST_REMAP;
            end
            ST_REMAP: begin
                bist_busy = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                bist_done = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Route operands to the physical slices: mapped operands normally,
    // a single isolated test vector on slice k during TEST.
    always_comb begin
        pa   = '0;
        pb   = '0;
        used = '0;
        for (int i = 0; i < WIDTH; i++) begin
            used[map[i]] = 1'b1;
            pa[map[i]]   = a[i];
            pb[map[i]]   = b[i];
        end
        if (test_mode) begin
            pa    = '0;
            pb    = '0;
            pa[k] = v[2];
            pb[k] = v[1];
        end
    end

    // Physical slices. The carry walks the slices in physical order and
    // skips unused ones; because the map is always ascending this equals
    // logical order and has no combinational loop.
    for (genvar p = 0; p < P; p++) begin : g_slice
        logic      chain_in, chain_out, ci, co;
        inj_mode_e mode;

        if (p == 0) begin : g_first
            assign chain_in = cin;
        end else begin : g_rest
            assign chain_in = g_slice[p-1].chain_out;
        end

        assign ci        = test_mode ? ((k == IDX_W'(p)) & v[0]) : chain_in;
        assign chain_out = used[p] ? co : chain_in;
        assign mode      = (inj_en && inj_slice == IDX_W'(p)) ? inj_mode_e'(inj_mode) : INJ_NONE;
        assign slice_c[p] = co;

        ft_fa_slice u_fa (
            .a    (pa[p]),
            .b    (pb[p]),
            .ci   (ci),
            .mode (mode),
            .s    (slice_s[p]),
            .co   (co)
        );
    end

    assign golden   = fa_golden(v[2], v[1], v[0]);
    assign cout_nxt = g_slice[P-1].chain_out;

    // Gather the logical sum bits from their physical slices.
    always_comb begin
        sum_nxt = '0;
        for (int i = 0; i < WIDTH; i++) sum_nxt[i] = slice_s[map[i]];
    end

    // Build the candidate map: logical i onto the i-th healthy slice.
    always_comb begin
        faulty    = sf | cf;
        free_cnt  = 0;
        fault_cnt = 0;
        for (int i = 0; i < WIDTH; i++) remap[i] = IDX_W'(i);
        for (int p = 0; p < P; p++) begin
            if (faulty[p]) begin
                fault_cnt++;
            end else begin
                for (int i = 0; i < WIDTH; i++)
                    if (free_cnt == i) remap[i] = IDX_W'(p);
                free_cnt++;
            end
        end
        repairable = (fault_cnt <= SPARES);
    end

    // BIST counters, sticky fault maps and the slice map.
    always_ff @(posedge clk) begin
        if (init) begin
            k            <= '0;
            v            <= '0;
            sf           <= '0;
            cf           <= '0;
            unrepairable <= 1'b0;
            // NOTE: the map is a register array but must reset, since identity is the working default.
            for (int i = 0; i < WIDTH; i++) map[i] <= IDX_W'(i);
        end else begin
            if (state == ST_TEST) begin
                v <= v + 3'd1;
                if (v == 3'd7) k <= k + IDX_W'(1);
                if (slice_s[k] != golden[0]) sf[k] <= 1'b1;
                if (slice_c[k] != golden[1]) cf[k] <= 1'b1;
            end else begin
                k <= '0;
                v <= '0;
            end
            if (state == ST_REMAP) begin
                unrepairable <= !repairable;
                if (repairable)
                    for (int i = 0; i < WIDTH; i++) map[i] <= remap[i];
            end
        end
    end

    // Result register; operands offered while BIST is busy are dropped.
    always_ff @(posedge clk) begin
        if (init) begin
            s         <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid && !bist_busy;
            if (in_valid && !bist_busy) begin
                s    <= sum_nxt;
                cout <= cout_nxt;
            end
        end
    end

endmodule

// File: tb/tb_rca_ft_reconfig.sv
// Directed bench for rca_ft_reconfig (WIDTH=4, SPARES=1, P=5).
module tb_rca_ft_reconfig;

    localparam int WIDTH  = 4;
    localparam int SPARES = 1;
    localparam int P      = WIDTH + SPARES;
    localparam int IDX_W  = 3;

    logic             clk = 1'b0;
    logic             init;
    logic [WIDTH-1:0] a, b;
    logic             cin, in_valid;
    logic [WIDTH-1:0] s;
    logic             cout, out_valid;
    logic             start_bist, bist_busy, bist_done;
    logic [P-1:0]     sf, cf;
    logic             unrepairable;
    logic             inj_en;
    logic [IDX_W-1:0] inj_slice;
    logic [1:0]       inj_mode;

    int n_checks = 0;
    int n_fail   = 0;

    rca_ft_reconfig #(.WIDTH(WIDTH), .SPARES(SPARES)) dut (
        .clk          (clk),
        .init         (init),
        .a            (a),
        .b            (b),
        .cin          (cin),
        .in_valid     (in_valid),
        .s            (s),
        .cout         (cout),
        .out_valid    (out_valid),
        .start_bist   (start_bist),
        .bist_busy    (bist_busy),
        .bist_done    (bist_done),
        .sf           (sf),
        .cf           (cf),
        .unrepairable (unrepairable),
        .inj_en       (inj_en),
        .inj_slice    (inj_slice),
        .inj_mode     (inj_mode)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_add(input logic [3:0] aa, input logic [3:0] bb, input logic c);
        a = aa; b = bb; cin = c; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_sum(input string name, input logic [3:0] exp_s, input logic exp_c);
        n_checks++;
        if (s !== exp_s || cout !== exp_c || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got s=%0d cout=%b ov=%b, expected s=%0d cout=%b ov=1",
                     name, s, cout, out_valid, exp_s, exp_c);
        end
    endtask

    task automatic run_bist();
        int cycles;
        cycles = 0;
        start_bist = 1'b1;
        step();
        start_bist = 1'b0;
        while (bist_busy === 1'b1 && cycles < 200) begin
            cycles++;
            step();
        end
        n_checks++;
        if (cycles !== 41) begin
            n_fail++;
            $display("FAIL bist_busy_len: got %0d cycles, expected 41", cycles);
        end
        n_checks++;
        if (bist_done !== 1'b1) begin
            n_fail++;
            $display("FAIL bist_done_pulse: got %b, expected 1 at start+42", bist_done);
        end
        step();
        n_checks++;
        if (bist_done !== 1'b0 || bist_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bist_done_width: got done=%b busy=%b, expected 0/0", bist_done, bist_busy);
        end
    endtask

    task automatic test_reset();
        init = 1'b1;
        step();
        step();
        n_checks++;
        if ({s, cout, out_valid, bist_busy, bist_done, unrepairable} !== 9'b0 || sf !== 5'b0 || cf !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state: got s=%0d cout=%b ov=%b busy=%b done=%b unrep=%b sf=%b cf=%b, expected all 0",
                     s, cout, out_valid, bist_busy, bist_done, unrepairable, sf, cf);
        end
        init = 1'b0;
        step();
    endtask

    task automatic test_add();
        do_add(4'd5, 4'd3, 1'b0);
        check_sum("add_5_3", 4'd8, 1'b0);
        do_add(4'd15, 4'd1, 1'b0);
        check_sum("add_15_1", 4'd0, 1'b1);
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_out_valid: got %b, expected 0", out_valid);
        end
    endtask

    task automatic test_bist_clean();
        run_bist();
        n_checks++;
        if (sf !== 5'b0 || cf !== 5'b0 || unrepairable !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_bist_maps: got sf=%b cf=%b unrep=%b, expected 00000/00000/0", sf, cf, unrepairable);
        end
        do_add(4'd7, 4'd9, 1'b1);
        check_sum("clean_add_7_9_1", 4'd1, 1'b1);
    endtask

    task automatic test_inject_repair();
        inj_en = 1'b1; inj_slice = 3'd2; inj_mode = 2'b10;
        do_add(4'd0, 4'd0, 1'b0);
        check_sum("inject_identity_sum1", 4'd4, 1'b0);
        run_bist();
        n_checks++;
        if (sf !== 5'b00100 || cf !== 5'b0 || unrepairable !== 1'b0) begin
            n_fail++;
            $display("FAIL repair_maps: got sf=%b cf=%b unrep=%b, expected 00100/00000/0", sf, cf, unrepairable);
        end
        do_add(4'd10, 4'd5, 1'b0);
        check_sum("repaired_add_10_5", 4'd15, 1'b0);
        do_add(4'd15, 4'd1, 1'b0);
        check_sum("repaired_carry_bypass", 4'd0, 1'b1);
    endtask

    task automatic test_unrepairable();
        inj_slice = 3'd0; inj_mode = 2'b11;
        run_bist();
        n_checks++;
        if (sf !== 5'b00100 || cf !== 5'b00001 || unrepairable !== 1'b1) begin
            n_fail++;
            $display("FAIL unrepairable_maps: got sf=%b cf=%b unrep=%b, expected 00100/00001/1", sf, cf, unrepairable);
        end
        inj_slice = 3'd2; inj_mode = 2'b10;
        do_add(4'd0, 4'd0, 1'b0);
        check_sum("map_unchanged_slice2_bypassed", 4'd0, 1'b0);
    endtask

    task automatic test_abort();
        int done_seen;
        done_seen = 0;
        inj_slice = 3'd0; inj_mode = 2'b01;
        start_bist = 1'b1;
        step();
        start_bist = 1'b0;
        repeat (9) step();
        init = 1'b1;
        step();
        init = 1'b0;
        n_checks++;
        if (bist_busy !== 1'b0 || sf !== 5'b0 || cf !== 5'b0 || unrepairable !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: got busy=%b sf=%b cf=%b unrep=%b, expected 0/00000/00000/0",
                     bist_busy, sf, cf, unrepairable);
        end
        for (int i = 0; i < 50; i++) begin
            if (bist_done === 1'b1) done_seen++;
            step();
        end
        n_checks++;
        if (done_seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done pulses, expected 0", done_seen);
        end
        inj_slice = 3'd2; inj_mode = 2'b10;
        do_add(4'd0, 4'd0, 1'b0);
        check_sum("abort_identity_map", 4'd4, 1'b0);
        inj_slice = 3'd7;
        do_add(4'd0, 4'd0, 1'b0);
        check_sum("inj_slice_out_of_range", 4'd0, 1'b0);
        inj_en = 1'b0; inj_mode = 2'b00; inj_slice = 3'd0;
    endtask

    task automatic test_drop_during_busy();
        int cycles;
        int bad;
        cycles = 0;
        bad    = 0;
        do_add(4'd6, 4'd2, 1'b0);
        check_sum("pre_busy_add", 4'd8, 1'b0);
        start_bist = 1'b1;
        step();
        start_bist = 1'b0;
        a = 4'd1; b = 4'd1; cin = 1'b0; in_valid = 1'b1;
        while (bist_busy === 1'b1 && cycles < 200) begin
            cycles++;
            start_bist = (cycles == 5);
            step();
            if (out_valid !== 1'b0 || s !== 4'd8) bad++;
        end
        start_bist = 1'b0;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL busy_drop: got %0d cycles with output change, expected 0", bad);
        end
        n_checks++;
        if (cycles !== 41 || bist_done !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_ignored: got %0d busy cycles done=%b, expected 41 and 1", cycles, bist_done);
        end
        step();
        in_valid = 1'b0;
        check_sum("accept_in_done_cycle", 4'd2, 1'b0);
    endtask

    task automatic test_back_to_back();
        int cycles;
        cycles = 0;
        a = 4'd3; b = 4'd4; cin = 1'b0; in_valid = 1'b1; start_bist = 1'b1;
        step();
        in_valid = 1'b0; start_bist = 1'b0;
        check_sum("same_cycle_add", 4'd7, 1'b0);
        n_checks++;
        if (bist_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_bist_start: got busy=%b, expected 1", bist_busy);
        end
        while (bist_busy === 1'b1 && cycles < 200) begin
            cycles++;
            step();
        end
        n_checks++;
        if (cycles !== 41 || bist_done !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_bist_len: got %0d cycles done=%b, expected 41 and 1", cycles, bist_done);
        end
        step();
    endtask

    initial begin
        init = 1'b1; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0; start_bist = 1'b0;
        inj_en = 1'b0; inj_slice = '0; inj_mode = 2'b00;
        test_reset();
        test_add();
        test_bist_clean();
        test_inject_repair();
        test_unrepairable();
        test_abort();
        test_drop_during_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
